// File: rtl/ir_cycle_sequencer.sv
// Instruction register, T-step / M-cycle counters and IR group decode for the control unit.
// Optional CB-prefix tracking is enabled by defining CB_PREFIX_EN.
module ir_cycle_sequencer #(
   parameter logic [7:0]  RESET_OPCODE    = 8'h00,
   parameter int unsigned LOCK_ON_ILLEGAL = 1
) (
   input  logic       i_Clk,
   input  logic       i_Rst_n,
   input  logic       i_Fetch,
   input  logic       i_Wait,
   input  logic [7:0] i_Bus_Data,
   output logic [3:0] o_Cycle_Step,
   output logic [7:0] o_Cycle_Count,
   output logic [7:0] o_IR,
   output logic [3:0] o_X,
   output logic [7:0] o_Y,
   output logic [7:0] o_Z,
   output logic [3:0] o_P,
   output logic [1:0] o_Q,
   output logic       o_CB,
   output logic       o_Locked
);

   logic [3:0] r_step;
   logic [7:0] r_count;
   logic [7:0] r_ir;
   logic       r_locked;

   logic       w_advance;
   logic       w_load;
   logic       w_illegal;
   logic       w_second_byte;
   logic       w_lock_now;
   logic       w_cb;

   always_comb begin
      w_illegal = 1'b0;
      case (i_Bus_Data)
         8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
         8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: w_illegal = 1'b1;
         default:                           w_illegal = 1'b0;
      endcase
   end

   assign w_advance  = !i_Wait && !r_locked;
   assign w_load     = w_advance && r_step[3] && i_Fetch;
   // The byte after a CB prefix comes from a table with no illegal entries.
   assign w_lock_now = (LOCK_ON_ILLEGAL != 0) && w_illegal && !w_second_byte;

`ifdef CB_PREFIX_EN
   logic r_cb;
   logic r_cb_pre;

   // r_cb_pre marks that the IR holds the prefix byte itself, so the next load is its operand.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_cb     <= 1'b0;
         r_cb_pre <= 1'b0;
      end else if (w_load) begin
         if (r_cb_pre) begin
            r_cb     <= 1'b1;
            r_cb_pre <= 1'b0;
         end else if (i_Bus_Data == 8'hCB) begin
            r_cb     <= 1'b1;
            r_cb_pre <= 1'b1;
         end else begin
            r_cb     <= 1'b0;
            r_cb_pre <= 1'b0;
         end
      end
   end

   assign w_cb          = r_cb;
   assign w_second_byte = r_cb_pre;
`else
   assign w_cb          = 1'b0;
   assign w_second_byte = 1'b0;
`endif

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_step   <= 4'b0001;
         r_count  <= 8'h01;
         r_ir     <= RESET_OPCODE;
         r_locked <= 1'b0;
      end else if (w_advance) begin
         r_step <= {r_step[2:0], r_step[3]};
         if (r_step[3]) begin
            if (i_Fetch) begin
               r_ir    <= i_Bus_Data;
               r_count <= 8'h01;
               if (w_lock_now) begin
                  r_locked <= 1'b1;
               end
            end else if (!r_count[7]) begin
               r_count <= {r_count[6:0], 1'b0};
            end
         end
      end
   end

   assign o_Cycle_Step  = r_step;
   assign o_Cycle_Count = r_count;
   assign o_IR          = r_ir;
   assign o_X           = 4'b0001 << r_ir[7:6];
   assign o_Y           = 8'h01 << r_ir[5:3];
   assign o_Z           = 8'h01 << r_ir[2:0];
   assign o_P           = 4'b0001 << r_ir[5:4];
   assign o_Q           = 2'b01 << r_ir[3];
   assign o_CB          = w_cb;
   assign o_Locked      = r_locked;

endmodule
